// File: rtl/iob_mem_arbiter_pkg.sv
// Shared definitions for the IOb memory arbiter: FSM encoding and packed-bus field offsets.
// Requests pack {valid, addr, wdata, wstrb}; responses pack {rdata, ready}; master 0 sits in LSBs.
package iob_mem_arbiter_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  function automatic int unsigned req_w(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw + dw / 8;
  endfunction

  function automatic int unsigned resp_w(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned req_wstrb_lsb(input int unsigned i, input int unsigned aw,
                                                input int unsigned dw);
    return i * req_w(aw, dw);
  endfunction

  function automatic int unsigned req_wdata_lsb(input int unsigned i, input int unsigned aw,
                                                input int unsigned dw);
    return req_wstrb_lsb(i, aw, dw) + dw / 8;
  endfunction

  function automatic int unsigned req_addr_lsb(input int unsigned i, input int unsigned aw,
                                               input int unsigned dw);
    return req_wdata_lsb(i, aw, dw) + dw;
  endfunction

  function automatic int unsigned req_valid_bit(input int unsigned i, input int unsigned aw,
                                                input int unsigned dw);
    return req_addr_lsb(i, aw, dw) + aw;
  endfunction

  function automatic int unsigned resp_ready_bit(input int unsigned i, input int unsigned dw);
    return i * resp_w(dw);
  endfunction

  function automatic int unsigned resp_rdata_lsb(input int unsigned i, input int unsigned dw);
    return resp_ready_bit(i, dw) + 1;
  endfunction

endpackage

// File: rtl/iob_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N-1.
// Returns a one-hot winner, its index and whether any request was set.
module iob_rr_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [PtrW-1:0] idx_o,
  output logic            any_o
);

  logic [PtrW-1:0] cand;
  logic            found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = ptr_i;
    for (int k = 0; k < int'(N); k++) begin
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
      // Explicit compare so non-power-of-two N wraps correctly.
      cand = (cand == PtrW'(N - 1)) ? '0 : cand + 1'b1;
    end
    any_o = found;
  end

endmodule

// File: rtl/iob_mem_arbiter.sv
// Round-robin arbiter sharing one IOb slave between N_MASTERS masters.
// One transaction in flight; grant is registered and held until the slave returns ready.
module iob_mem_arbiter
  import iob_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REQ_W     = 1 + ADDR_W + DATA_W + DATA_W / 8,
  parameter int unsigned RESP_W    = DATA_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp,
  output logic [N_MASTERS-1:0]          grant,
  output logic                          busy
);

  localparam int unsigned PtrW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  arb_state_e            state_q, state_d;
  logic [N_MASTERS-1:0]  grant_q, grant_d;
  logic [PtrW-1:0]       idx_q, idx_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;

  logic [N_MASTERS-1:0]  req_valid;
  logic [N_MASTERS-1:0]  pick_gnt;
  logic [PtrW-1:0]       pick_idx;
  logic                  pick_any;
  logic                  s_ready;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      req_valid[i] = m_req[req_valid_bit(i, ADDR_W, DATA_W)];
    end
  end

  assign s_ready = s_resp[resp_ready_bit(0, DATA_W)];

  iob_rr_pick #(
    .N    (N_MASTERS),
    .PtrW (PtrW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    s_req   = '0;
    m_resp  = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          idx_d   = pick_idx;
          state_d = StBusy;
        end
      end
      StBusy: begin
        for (int i = 0; i < int'(N_MASTERS); i++) begin
          if (grant_q[i]) begin
            s_req = m_req[req_wstrb_lsb(i, ADDR_W, DATA_W) +: REQ_W];
            // Non-granted masters and not-ready cycles see an all-zero response.
            if (s_ready) begin
              m_resp[resp_ready_bit(i, DATA_W) +: RESP_W] = s_resp;
            end
          end
        end
        if (s_ready) begin
          ptr_d   = (idx_q == PtrW'(N_MASTERS - 1)) ? '0 : idx_q + 1'b1;
          grant_d = '0;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == StBusy);

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// Directed bench for iob_mem_arbiter with three masters and 32-bit address/data.
module tb_iob_mem_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned RQ = 1 + AW + DW + SW;
  localparam int unsigned RS = DW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*RQ-1:0]   m_req;
  logic [N*RS-1:0]   m_resp;
  logic [RQ-1:0]     s_req;
  logic [RS-1:0]     s_resp;
  logic [N-1:0]      grant;
  logic              busy;

  int vecs = 0;
  int errs = 0;

  logic [N*RS-1:0]   exp_resp;

  iob_mem_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .REQ_W     (RQ),
    .RESP_W    (RS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m_req  (m_req),
    .m_resp (m_resp),
    .s_req  (s_req),
    .s_resp (s_resp),
    .grant  (grant),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int m, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    m_req[m*RQ +: RQ] = {v, a, d, s};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < int'(N*RQ); i++) m_req[i] = 1'($urandom);
    s_resp = {32'($urandom), 1'b1};
    #3;
    vecs++; if (grant !== 3'b000) begin errs++; $display("FAIL rst_grant got %b want 000", grant); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
    vecs++; if (s_req !== '0) begin errs++; $display("FAIL rst_s_req got %h want 0", s_req); end
    vecs++; if (m_resp !== '0) begin errs++; $display("FAIL rst_m_resp got %h want 0", m_resp); end
    m_req = '0;
    s_resp = '0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy got %b want 0", busy); end
    vecs++; if (grant !== 3'b000) begin errs++; $display("FAIL idle_grant got %b want 000", grant); end
    // Stray slave ready in IDLE must not reach any master.
    s_resp = {32'hCAFEF00D, 1'b1};
    #1;
    vecs++; if (m_resp !== '0) begin errs++; $display("FAIL idle_ready_leak got %h want 0", m_resp); end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_ready_busy got %b want 0", busy); end
    s_resp = '0;
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 32'h100, 32'h0, 4'h0);
    #1;
    vecs++; if (s_req !== '0) begin errs++; $display("FAIL rd_s_req_c0 got %h want 0", s_req); end
    tick();
    vecs++; if (grant !== 3'b001) begin errs++; $display("FAIL rd_grant got %b want 001", grant); end
    vecs++; if (s_req !== {1'b1, 32'h100, 32'h0, 4'h0}) begin
      errs++; $display("FAIL rd_s_req_c1 got %h want %h", s_req, {1'b1, 32'h100, 32'h0, 4'h0});
    end
    tick();
    vecs++; if (m_resp !== '0) begin errs++; $display("FAIL rd_resp_wait got %h want 0", m_resp); end
    tick();
    s_resp = {32'hDEADBEEF, 1'b1};
    #1;
    exp_resp = '0;
    exp_resp[0 +: RS] = {32'hDEADBEEF, 1'b1};
    vecs++; if (m_resp !== exp_resp) begin
      errs++; $display("FAIL rd_resp got %h want %h", m_resp, exp_resp);
    end
    tick();
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_resp = '0;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rd_done_busy got %b want 0", busy); end
    vecs++; if (dut.ptr_q !== 2'd1) begin errs++; $display("FAIL rd_ptr got %0d want 1", dut.ptr_q); end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_g [4];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b001; exp_g[3] = 3'b010;
    rst = 1'b0;
    set_req(0, 1'b1, 32'h10, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h20, 32'h0, 4'h0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vecs++; if (grant !== exp_g[k]) begin
        errs++; $display("FAIL cont_grant_%0d got %b want %b", k, grant, exp_g[k]);
      end
      s_resp = {32'(k + 32'hA0), 1'b1};
      #1;
      exp_resp = '0;
      exp_resp[(exp_g[k] == 3'b001 ? 0 : 1) * RS +: RS] = {32'(k + 32'hA0), 1'b1};
      vecs++; if (m_resp !== exp_resp) begin
        errs++; $display("FAIL cont_resp_%0d got %h want %h", k, m_resp, exp_resp);
      end
      tick();
      s_resp = '0;
      if (k == 3) begin
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      #1;
      vecs++; if (grant !== 3'b000 || busy !== 1'b0) begin
        errs++; $display("FAIL cont_turn_%0d got grant=%b busy=%b want 000/0", k, grant, busy);
      end
    end
  endtask

  task automatic test_write();
    set_req(1, 1'b1, 32'h200, 32'h12345678, 4'hF);
    tick();
    vecs++; if (grant !== 3'b010) begin errs++; $display("FAIL wr_grant got %b want 010", grant); end
    vecs++; if (s_req !== {1'b1, 32'h200, 32'h12345678, 4'hF}) begin
      errs++; $display("FAIL wr_s_req got %h want %h", s_req, {1'b1, 32'h200, 32'h12345678, 4'hF});
    end
    tick();
    s_resp = {32'h0, 1'b1};
    #1;
    exp_resp = '0;
    exp_resp[1*RS +: RS] = {32'h0, 1'b1};
    vecs++; if (m_resp !== exp_resp) begin
      errs++; $display("FAIL wr_resp got %h want %h", m_resp, exp_resp);
    end
    tick();
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    s_resp = '0;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL wr_done_busy got %b want 0", busy); end
    tick();
    vecs++; if (m_resp !== '0 || busy !== 1'b0) begin
      errs++; $display("FAIL wr_single_pulse got resp=%h busy=%b want 0/0", m_resp, busy);
    end
  endtask

  task automatic test_reset_mid();
    // ptr is 2 here, so m2 wins first; after reset ptr=0 must favour m0.
    set_req(0, 1'b1, 32'h300, 32'h0, 4'h0);
    set_req(2, 1'b1, 32'h380, 32'h0, 4'h0);
    tick();
    vecs++; if (grant !== 3'b100) begin errs++; $display("FAIL mid_pre_grant got %b want 100", grant); end
    #1;
    rst = 1'b0;
    #1;
    vecs++; if (grant !== 3'b000) begin errs++; $display("FAIL mid_grant got %b want 000", grant); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy got %b want 0", busy); end
    vecs++; if (s_req[RQ-1] !== 1'b0) begin
      errs++; $display("FAIL mid_s_valid got %b want 0", s_req[RQ-1]);
    end
    tick();
    rst = 1'b1;
    tick();
    vecs++; if (grant !== 3'b001) begin errs++; $display("FAIL mid_rearb got %b want 001", grant); end
    s_resp = {32'h55, 1'b1};
    tick();
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(2, 1'b0, 32'h0, 32'h0, 4'h0);
    s_resp = '0;
    #1;
    vecs++; if (dut.ptr_q !== 2'd1) begin errs++; $display("FAIL mid_ptr got %0d want 1", dut.ptr_q); end
  endtask

  task automatic test_wrap();
    logic [N-1:0] mask  [3];
    logic [N-1:0] exp_g [3];
    logic [1:0]   exp_p [3];
    mask[0] = 3'b010; exp_g[0] = 3'b010; exp_p[0] = 2'd2;
    mask[1] = 3'b100; exp_g[1] = 3'b100; exp_p[1] = 2'd0;
    mask[2] = 3'b101; exp_g[2] = 3'b001; exp_p[2] = 2'd1;
    for (int k = 0; k < 3; k++) begin
      for (int m = 0; m < int'(N); m++) set_req(m, mask[k][m], 32'(32'h400 + m), 32'h0, 4'h0);
      tick();
      vecs++; if (grant !== exp_g[k]) begin
        errs++; $display("FAIL wrap_grant_%0d got %b want %b", k, grant, exp_g[k]);
      end
      s_resp = {32'h77, 1'b1};
      tick();
      m_req = '0;
      s_resp = '0;
      #1;
      vecs++; if (dut.ptr_q !== exp_p[k]) begin
        errs++; $display("FAIL wrap_ptr_%0d got %0d want %0d", k, dut.ptr_q, exp_p[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    m_req = '0;
    s_resp = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/iob_mem_arbiter.md
Name: iob_mem_arbiter

Overview:
- Round-robin arbiter that shares one IOb-native slave port (external memory controller) between N_MASTERS IOb-native masters, e.g. the instruction and data buses after the internal/external split.
- Only one transaction is outstanding at a time.
- The grant is registered and held until the slave returns ready.
- The response is routed back only to the granted master.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..8).
- ADDR_W, 32, request address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- REQ_W, 1+ADDR_W+DATA_W+DATA_W/8, packed request {valid, addr, wdata, wstrb}.
- RESP_W, DATA_W+1, packed response {rdata, ready}.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- m_req  in  N_MASTERS*REQ_W  packed master requests; master 0 in the LSBs.
- m_resp  out  N_MASTERS*RESP_W  packed master responses.
- s_req  out  REQ_W  request to the shared slave.
- s_resp  in  RESP_W  response from the shared slave.
- grant  out  N_MASTERS  one-hot owner of the slave; all-zero when idle.
- busy  out  1  high while a transaction is in flight.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, grant=0, busy=0, priority pointer ptr=0.
  - s_req=0; every m_resp=0.
- Bus protocol: a master asserts valid and holds valid/addr/wdata/wstrb stable until it sees ready for one cycle. wstrb=0 means read.
- FSM with two states:
  - IDLE: s_req valid=0. If any master valid=1, choose the winner as the first valid index searching ptr, ptr+1, ... modulo N_MASTERS. Register grant (one-hot), set busy=1, go to BUSY. If no master is valid, stay in IDLE.
  - BUSY: s_req = granted master's request field, passed combinationally from m_req. On s_resp ready=1:
    - the granted master's m_resp = s_resp for that cycle; all other m_resp stay 0;
    - ptr <= granted index + 1 (wraps to 0 after N_MASTERS-1);
    - grant <= 0, busy <= 0, next state IDLE.
- Latency: first s_req valid appears 1 cycle after master valid. Master ready arrives the same cycle as slave ready. Minimum cycle-to-cycle turnaround is 2 clocks: the BUSY cycle with ready, then an IDLE arbitration cycle.
- Non-granted masters see ready=0 and rdata=0; their pending requests wait.
- Simultaneous requests resolve by round-robin order only. No master waits longer than N_MASTERS-1 transactions.
- A master that deasserts valid before ready has violated protocol. The arbiter still completes the slave transaction, using whatever is on that master's lines.
- Reset asserted mid-BUSY aborts immediately to IDLE. The slave is expected to be reset by the same rst.
- s_resp ready while in IDLE is ignored (no m_resp ready generated).
- Width rules: ptr width is $clog2(N_MASTERS), min 1. Wrap uses an explicit compare against N_MASTERS-1, not a power-of-two mask.

Decomposition:
- Shared package/header holds:
  - REQ_W/RESP_W field macros: valid(i), address(i,W), wdata(i), wstrb(i), rdata(i), ready(i);
  - FSM state encodings IDLE=1'b0, BUSY=1'b1.
- One sub-module: iob_rr_pick. Purely combinational. Takes a request vector and ptr; returns a one-hot winner and its index. Reusable by other arbiters.
- Top level holds the FSM, the grant/ptr registers and the request/response muxing.

Test Plan:
- Reset: hold rst=0 with random m_req -> grant=0, busy=0, s_req=0, all m_resp=0; after release with no valid, stays IDLE.
- Single read: m0 valid, addr=0x100, wstrb=0; slave ready 3 cycles later with rdata=0xDEADBEEF -> s_req valid from cycle 1, m0 ready with rdata 0xDEADBEEF on the same cycle as slave ready, m1 resp=0 throughout, ptr=1.
- Contention: m0 and m1 both valid at reset release -> order m0, m1, m0, m1 over 4 transactions; grant one-hot each time; no starvation.
- Write: m1 valid, wdata=0x12345678, wstrb=0xF, slave ready after 1 cycle -> s_req carries exact wdata/wstrb; m1 ready pulses once; then IDLE.
- Reset mid-transaction: rst=0 while BUSY before slave ready -> grant=0, busy=0, s_req valid=0 asynchronously; after release, a pending m0 request is re-arbitrated with ptr=0.
- Wrap with N_MASTERS=3: only m2 requests after ptr=2 -> after completion ptr=0; next, simultaneous m0 and m2 -> m0 wins.
